// File: rtl/conv_pkg.sv
// Shared geometry defaults, FSM encoding and packed-word width helper for layer weight sources.
package conv_pkg;
  localparam int CH_NUM_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  function automatic int word_w(input int ch_num, input int data_w);
    return ch_num * data_w;
  endfunction
endpackage

// File: rtl/weight_sdp_ram.sv
// Simple dual-port weight store: one write port, registered read gated by read enable.
// A same-address read and write in one cycle returns the old word; contents are loaded through the write port.
module weight_sdp_ram #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 576,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge sclk) begin
    if (i_wr_en && (32'(i_wr_addr) < DEPTH)) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Output register holds its word until the next read so stalled beats stay stable.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/conv_weight_stream_tx.sv
// Streams cfg_len words per pass for max(cfg_repeat,1) passes; first beat 2 edges after start, 1 beat/cycle.
// Beats (data/last/end) are held unchanged while weight_valid && !ready; reads only advance on acceptance.
module conv_weight_stream_tx
  import conv_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 576,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter     INIT_FILE = "",
  localparam int WORD_W   = word_w(CH_NUM, DATA_W)
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [7:0]        cfg_repeat,
  output logic              busy,
  output logic              done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] weight_data,
  output logic              weight_valid,
  output logic              weight_last,
  output logic              weight_end,
  input  logic              ready
);
  tx_state_t         r_state, w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [7:0]        r_rep;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_pass;
  logic              r_valid, r_last, r_end, r_done;
  logic              w_len_ok, w_start, w_ren, w_hs, w_word_last, w_pass_last;

  assign w_len_ok    = (cfg_len != '0) && (cfg_len <= (ADDR_W+1)'(DEPTH));
  assign w_start     = (r_state == ST_IDLE) && start && w_len_ok;
  assign w_hs        = r_valid && ready;
  assign w_ren       = (r_state == ST_RUN) && (!r_valid || ready);
  assign w_word_last = ({1'b0, r_addr} == (r_len - 1'b1));
  assign w_pass_last = (r_pass == (r_rep - 8'd1));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_ren && w_word_last && w_pass_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Geometry is frozen at start; repeat 0 is stored as a single pass.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_len  <= '0;
      r_rep  <= '0;
      r_addr <= '0;
      r_pass <= '0;
    end else if (w_start) begin
      r_len  <= cfg_len;
      r_rep  <= (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
      r_addr <= '0;
      r_pass <= '0;
    end else if (w_ren) begin
      if (w_word_last) begin
        r_addr <= '0;
        r_pass <= r_pass + 8'd1;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_end   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_hs;
      if (w_ren) begin
        r_valid <= 1'b1;
        r_last  <= w_word_last;
        r_end   <= w_word_last && w_pass_last;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  weight_sdp_ram #(
    .WIDTH    (WORD_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_rd_en  (w_ren),
    .i_rd_addr(r_addr),
    .o_rd_data(weight_data)
  );

  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign weight_valid = r_valid;
  assign weight_last  = r_last;
  assign weight_end   = r_end;
endmodule

// File: tb/tb_conv_weight_stream_tx.sv
// Scoreboard bench: expected beats are queued from a memory model at start; a negedge monitor checks handshakes.
module tb_conv_weight_stream_tx;
  localparam int CH    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 576;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = CH * DW;

  logic          sclk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic [7:0]    cfg_repeat = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          ready = 1'b0;
  logic          busy, done, weight_valid, weight_last, weight_end;
  logic [W-1:0]  weight_data;

  always #5 sclk = ~sclk;

  conv_weight_stream_tx #(
    .CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_repeat(cfg_repeat), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .weight_data(weight_data),
    .weight_valid(weight_valid), .weight_last(weight_last),
    .weight_end(weight_end), .ready(ready)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         e;
    int           word;
  } exp_t;

  exp_t         sb[$];
  int           hs_cyc[$];
  logic [W-1:0] mem_m [DEPTH];
  int           checks = 0, errors = 0, cyc = 0;
  int           exp_done = 0, done_seen = 0, end_cyc = -10;
  bit           rnd_ready = 1'b0, prev_hold = 1'b0;
  logic [W-1:0] prev_d;
  logic [1:0]   prev_f;
  exp_t         e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge values are what the next edge will see.
  always @(negedge sclk) begin
    cyc++;
    if (!s_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid_data", {63'd0, weight_valid} | (64'(weight_data != prev_d) << 1), 64'd1);
        check("hold_flags", 64'({weight_last, weight_end}), 64'(prev_f));
      end
      if (done) begin
        done_seen++;
        check("done_timing", 64'(cyc - 1), 64'(end_cyc));
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (weight_valid && ready) begin
        hs_cyc.push_back(cyc);
        if (weight_end) end_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data %h with nothing expected", weight_data);
        end else begin
          e = sb.pop_front();
          check("beat_data", weight_data, e.d);
          check("beat_flags", 64'({weight_last, weight_end}), 64'({e.l, e.e}));
        end
      end
      prev_hold = weight_valid && !ready;
      prev_d    = weight_data;
      prev_f    = {weight_last, weight_end};
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
    if (rnd_ready) ready = ($urandom_range(0, 1) == 1);
  endtask

  // Entries past the head have not been read yet, so a write updates them.
  task automatic mem_write(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    mem_m[a] = d;
    for (int i = 1; i < sb.size(); i++)
      if (sb[i].word == a) sb[i].d = d;
  endtask

  task automatic push_run(input int len, input int rep);
    exp_t x;
    int r;
    r = (rep == 0) ? 1 : rep;
    for (int p = 0; p < r; p++)
      for (int w = 0; w < len; w++) begin
        x.d = mem_m[w];
        x.l = (w == len - 1);
        x.e = (w == len - 1) && (p == r - 1);
        x.word = w;
        sb.push_back(x);
      end
    exp_done++;
  endtask

  task automatic do_start(input int len, input int rep);
    cfg_len = (AW+1)'(len); cfg_repeat = 8'(rep); start = 1'b1;
    tick();
    start = 1'b0;
    cfg_len = (AW+1)'($urandom); cfg_repeat = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && done_seen == exp_done && !busy) break;
      tick();
    end
    check("beats_left", 64'(sb.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(exp_done));
  endtask

  initial begin
    int len, rep, bad;
    #2;
    check("rst_valid", 64'(weight_valid), 64'd0);
    check("rst_last_end", 64'({weight_last, weight_end}), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_data", weight_data, 64'd0);
    tick();
    s_rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_write(i, W'(i));

    // Full-depth single pass
    ready = 1'b1;
    push_run(576, 1);
    do_start(576, 1);
    wait_idle(800);
    check("busy_after_full", 64'(busy), 64'd0);

    // Latency, multi-pass without bubbles, ignored start while busy
    hs_cyc.delete();
    push_run(4, 3);
    do_start(4, 3);
    check("busy_after_start", 64'(busy), 64'd1);
    check("valid_before_read", 64'(weight_valid), 64'd0);
    tick();
    check("first_valid", 64'(weight_valid), 64'd1);
    cfg_len = 2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(60);
    check("beats_4x3", 64'(hs_cyc.size()), 64'd12);
    if (hs_cyc.size() > 0)
      check("no_gaps", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'(hs_cyc.size() - 1));

    // Random contents, random ready
    for (int i = 0; i < 64; i++) mem_write(i, {$urandom, $urandom});
    rnd_ready = 1'b1;
    push_run(8, 1);
    do_start(8, 1);
    wait_idle(300);
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 40);
      rep = $urandom_range(0, 3);
      push_run(len, rep);
      do_start(len, rep);
      wait_idle(len * ((rep == 0) ? 1 : rep) * 10 + 60);
    end
    rnd_ready = 1'b0;
    ready = 1'b1;

    // Illegal lengths
    bad = 0;
    do_start(0, 1);
    if (busy || done) bad++;
    do_start(577, 2);
    for (int i = 0; i < 8; i++) begin
      if (busy || done) bad++;
      tick();
    end
    check("illegal_start_ignored", 64'(bad), 64'd0);
    check("illegal_no_done", 64'(done_seen), 64'(exp_done));

    // Mid-run writes while stalled at beat 4
    ready = 1'b0;
    hs_cyc.delete();
    push_run(16, 2);
    do_start(16, 2);
    for (int i = 0; i < 20 && !weight_valid; i++) tick();
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hs_cyc.size() >= 4) break;
    end
    ready = 1'b0;
    check("stall_at_beat4", 64'(hs_cyc.size()), 64'd4);
    mem_write(10, {8{8'hAA}});
    mem_write(2, {8{8'h55}});
    ready = 1'b1;
    wait_idle(100);

    // Reset mid-run, then restart with memory intact
    hs_cyc.delete();
    push_run(16, 1);
    do_start(16, 1);
    for (int i = 0; i < 40; i++) begin
      if (hs_cyc.size() >= 5) break;
      tick();
    end
    check("reached_beat5", 64'(hs_cyc.size()), 64'd5);
    s_rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(weight_valid), 64'd0);
    check("midrst_busy_done", 64'({busy, done}), 64'd0);
    sb.delete();
    exp_done = done_seen;
    tick();
    s_rst_n = 1'b1;
    tick();
    push_run(16, 1);
    do_start(16, 1);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
